ibex_instr_bus_responder: RTL and testbench

Memory-side responder for the Ibex instruction fetch interface. It accepts requests from the core's prefetch path (req/gnt address phase, rvalid/rdata/err data phase) and serves them from a single-port, one-cycle-latency instruction SRAM. Addresses outside the mapped region complete with an error response. It sits between `ibex_core`'s `instr_*` port and the instruction RAM in the top level, and supports multiple outstanding requests with strictly in-order responses.

---
 rtl/ibex_instr_bus_responder.sv | 125 ++++++++++++
 tb/tb_ibex_instr_bus_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_instr_bus_responder.sv
// Instruction-fetch bus responder. An in-order request queue sits in front of a
// single-port instruction SRAM with one-cycle read latency; unmapped addresses return errors.
module ibex_instr_bus_responder #(
   parameter logic [31:0] BaseAddr       = 32'h0010_0000,
   parameter int unsigned MemAw          = 14,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             instr_req_i,
   input  logic [31:0]      instr_addr_i,
   output logic             instr_gnt_o,
   output logic             instr_rvalid_o,
   output logic [31:0]      instr_rdata_o,
   output logic             instr_err_o,
   output logic             mem_req_o,
   input  logic             mem_gnt_i,
   output logic [MemAw-1:0] mem_addr_o,
   input  logic [31:0]      mem_rdata_i
);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;
   typedef struct packed {
      logic             valid;
      logic             issued;
      logic             err;
      logic [MemAw-1:0] word_addr;
   } entry_t;

   localparam ptr_t LastPtr  = ptr_t'(MaxOutstanding - 1);
   localparam cnt_t Capacity = cnt_t'(MaxOutstanding);

   entry_t queue_q [MaxOutstanding];
   entry_t queue_d [MaxOutstanding];
   ptr_t   wr_ptr_q, wr_ptr_d, iss_ptr_q, iss_ptr_d, rd_ptr_q, rd_ptr_d;
   cnt_t   count_q, count_d;
   logic   inflight_mem_q, inflight_mem_d, inflight_err_q, inflight_err_d;
   logic   active_q;

   logic [31:0] addr_off;
   logic        req_err;
   entry_t      iss_entry;
   logic        iss_pending, issue, resp_pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == LastPtr) ? '0 : p + ptr_t'(1);
   endfunction

   // Range check uses wrap-around subtraction so addresses below the base also fault.
   assign addr_off = instr_addr_i - BaseAddr;
   assign req_err  = |(addr_off >> (MemAw + 2));

   assign resp_pop    = inflight_mem_q | inflight_err_q;
   assign instr_gnt_o = instr_req_i & active_q & ((count_q < Capacity) | resp_pop);

   assign iss_entry   = queue_q[iss_ptr_q];
   assign iss_pending = iss_entry.valid & ~iss_entry.issued;
   assign mem_req_o   = iss_pending & ~iss_entry.err;
   assign mem_addr_o  = mem_req_o ? iss_entry.word_addr : '0;
   assign issue       = iss_pending & (iss_entry.err | mem_gnt_i);

   assign instr_rvalid_o = resp_pop;
   assign instr_err_o    = inflight_err_q;
   assign instr_rdata_o  = inflight_mem_q ? mem_rdata_i : '0;

   // NOTE: combinational next-state logic uses blocking assignments with every
   // target given a default first, so no latch can be inferred.
   always_comb begin
      queue_d        = queue_q;
      wr_ptr_d       = wr_ptr_q;
      iss_ptr_d      = iss_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      inflight_mem_d = 1'b0;
      inflight_err_d = 1'b0;

      if (resp_pop) begin
         queue_d[rd_ptr_q].valid = 1'b0;
         rd_ptr_d                = ptr_inc(rd_ptr_q);
      end

      if (issue) begin
         queue_d[iss_ptr_q].issued = 1'b1;
         iss_ptr_d                 = ptr_inc(iss_ptr_q);
         inflight_mem_d            = ~iss_entry.err;
         inflight_err_d            = iss_entry.err;
      end

      // A grant into a full queue reuses the slot being popped, so the write comes last.
      if (instr_gnt_o) begin
         queue_d[wr_ptr_q] = '{valid: 1'b1, issued: 1'b0, err: req_err,
                               word_addr: addr_off[MemAw+1:2]};
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end

      count_d = count_q + cnt_t'(instr_gnt_o) - cnt_t'(resp_pop);
   end

   // NOTE: the queue is a handful of flops whose valid bits define occupancy,
   // so it is reset along with the pointers rather than left as uninitialised storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(MaxOutstanding); i++) queue_q[i] <= '0;
         wr_ptr_q       <= '0;
         iss_ptr_q      <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         inflight_mem_q <= 1'b0;
         inflight_err_q <= 1'b0;
         active_q       <= 1'b0;
      end else begin
         queue_q        <= queue_d;
         wr_ptr_q       <= wr_ptr_d;
         iss_ptr_q      <= iss_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         inflight_mem_q <= inflight_mem_d;
         inflight_err_q <= inflight_err_d;
         active_q       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Bench for ibex_instr_bus_responder: directed scenarios plus a randomized stream,
// scored against an address-to-response model and an SRAM model.
module tb_ibex_instr_bus_responder;
   localparam logic [31:0] BASE    = 32'h0010_0000;
   localparam int          MEM_AW  = 14;
   localparam int          MAX_OUT = 2;
   localparam logic [31:0] REGION  = 32'h0001_0000;

   logic              clk_i;
   logic              rst_ni;
   logic              instr_req_i;
   logic [31:0]       instr_addr_i;
   logic              instr_gnt_o;
   logic              instr_rvalid_o;
   logic [31:0]       instr_rdata_o;
   logic              instr_err_o;
   logic              mem_req_o;
   logic              mem_gnt_i;
   logic [MEM_AW-1:0] mem_addr_o;
   logic [31:0]       mem_rdata_i;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic [31:0] sram [16384];
   resp_t       exp_q [$];

   ibex_instr_bus_responder #(
      .BaseAddr      (BASE),
      .MemAw         (MEM_AW),
      .MaxOutstanding(MAX_OUT)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .instr_req_i   (instr_req_i),
      .instr_addr_i  (instr_addr_i),
      .instr_gnt_o   (instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o (instr_rdata_o),
      .instr_err_o   (instr_err_o),
      .mem_req_o     (mem_req_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_addr_o    (mem_addr_o),
      .mem_rdata_i   (mem_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // SRAM: data appears the cycle after a granted read strobe.
   initial mem_rdata_i = '0;
   always @(posedge clk_i) begin
      if (mem_req_o && mem_gnt_i) mem_rdata_i <= sram[mem_addr_o];
   end

   // Expected response for a byte address: mapped region is BASE .. BASE+64KiB-1.
   function automatic resp_t model(input logic [31:0] a);
      resp_t       r;
      logic [31:0] off;
      off = a - BASE;
      if (off >= REGION) begin
         r.data = '0;
         r.err  = 1'b1;
      end else begin
         r.data = sram[off / 4];
         r.err  = 1'b0;
      end
      return r;
   endfunction

   // Scoreboard: every grant enqueues an expected response, every rvalid consumes one.
   logic              prev_stall = 1'b0;
   logic [MEM_AW-1:0] prev_addr  = '0;
   always @(negedge clk_i) begin
      resp_t e;
      if (!rst_ni) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr) begin
               errors++;
               $display("FAIL mem_stall_hold: got req=%b addr=%h, expected req=1 addr=%h",
                        mem_req_o, mem_addr_o, prev_addr);
            end
         end
         prev_stall = mem_req_o && !mem_gnt_i;
         prev_addr  = mem_addr_o;
         if (instr_rvalid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected: got rvalid with rdata=%h err=%b, expected no response",
                        instr_rdata_o, instr_err_o);
            end else begin
               e = exp_q.pop_front();
               if (instr_rdata_o !== e.data || instr_err_o !== e.err) begin
                  errors++;
                  $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                           instr_rdata_o, instr_err_o, e.data, e.err);
               end
            end
         end
         if (instr_gnt_o === 1'b1) begin
            checks++;
            if (instr_req_i !== 1'b1) begin
               errors++;
               $display("FAIL gnt_without_req: got gnt=1 req=%b, expected req=1", instr_req_i);
            end
            exp_q.push_back(model(instr_addr_i));
         end
         checks++;
         if (exp_q.size() > MAX_OUT) begin
            errors++;
            $display("FAIL outstanding_limit: got %0d outstanding, expected at most %0d",
                     exp_q.size(), MAX_OUT);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_ni       = 1'b1;
      instr_req_i  = 1'b1;
      instr_addr_i = BASE;
      mem_gnt_i    = 1'b1;
      #1 rst_ni = 1'b0;
      #2;
      checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", instr_gnt_o); end
      checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", instr_rvalid_o); end
      checks++; if (instr_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", instr_rdata_o); end
      checks++; if (instr_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", instr_err_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req_o); end
      checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_o); end
      repeat (3) @(posedge clk_i);
      #1;
      instr_req_i = 1'b0;
      rst_ni      = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_single_fetch();
      sram[0] = 32'hDEAD_BEEF;
      tick();
      instr_req_i  = 1'b1;
      instr_addr_i = BASE;
      mem_gnt_i    = 1'b1;
      @(negedge clk_i);
      checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b expected 1", instr_gnt_o); end
      tick();
      instr_req_i = 1'b0;
      @(negedge clk_i);
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== '0) begin errors++; $display("FAIL single_mem_req: got req=%b addr=%h expected req=1 addr=0", mem_req_o, mem_addr_o); end
      checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_early_rvalid: got %b expected 0", instr_rvalid_o); end
      tick();
      @(negedge clk_i);
      checks++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hDEAD_BEEF || instr_err_o !== 1'b0) begin
         errors++; $display("FAIL single_resp: got rvalid=%b rdata=%h err=%b expected rvalid=1 rdata=deadbeef err=0", instr_rvalid_o, instr_rdata_o, instr_err_o);
      end
      tick();
      @(negedge clk_i);
      checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_rvalid_pulse: got %b expected 0", instr_rvalid_o); end
   endtask

   task automatic test_back_to_back();
      int w0;
      w0 = int'($urandom_range(0, 16383 - 8));
      mem_gnt_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         instr_req_i  = (i < 8);
         instr_addr_i = BASE + 32'(4 * (w0 + i));
         @(negedge clk_i);
         if (i < 8) begin
            checks++;
            if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected 1", i, instr_gnt_o); end
         end
         checks++;
         if (instr_rvalid_o !== (i >= 2 && i < 10)) begin
            errors++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", i, instr_rvalid_o, (i >= 2 && i < 10));
         end
      end
      instr_req_i = 1'b0;
   endtask

   task automatic test_out_of_range();
      tick();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0011_0000;
      @(negedge clk_i);
      checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL oor_gnt: got %b expected 1", instr_gnt_o); end
      tick();
      instr_req_i = 1'b0;
      @(negedge clk_i);
      checks++; if (mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL oor_t1: got mem_req=%b rvalid=%b expected 0 0", mem_req_o, instr_rvalid_o); end
      tick();
      @(negedge clk_i);
      checks++; if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b1 || instr_rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
         errors++; $display("FAIL oor_resp: got rvalid=%b err=%b rdata=%h mem_req=%b expected 1 1 0 0", instr_rvalid_o, instr_err_o, instr_rdata_o, mem_req_o);
      end
   endtask

   task automatic test_interleaved();
      logic [31:0] addrs [3];
      resp_t       e;
      int          sent = 0;
      int          got  = 0;
      addrs[0] = BASE + 32'(4 * $urandom_range(0, 16383));
      addrs[1] = BASE + 32'h0002_0000;
      addrs[2] = BASE + 32'(4 * $urandom_range(0, 16383));
      for (int c = 0; c < 20; c++) begin
         tick();
         if (sent == 3 && got == 3) break;
         instr_req_i  = (sent < 3);
         instr_addr_i = (sent < 3) ? addrs[sent] : 32'h0;
         @(negedge clk_i);
         if (instr_rvalid_o === 1'b1) begin
            if (got < 3) begin
               e = model(addrs[got]);
               checks++;
               if (instr_err_o !== e.err || instr_rdata_o !== e.data) begin
                  errors++; $display("FAIL interleave_resp[%0d]: got err=%b rdata=%h expected err=%b rdata=%h", got, instr_err_o, instr_rdata_o, e.err, e.data);
               end
            end
            got++;
         end
         if (instr_gnt_o === 1'b1) sent++;
      end
      instr_req_i = 1'b0;
      checks++;
      if (got != 3) begin errors++; $display("FAIL interleave_count: got %0d responses expected 3", got); end
   endtask

   task automatic test_backpressure();
      logic [31:0] addrs [4];
      int          sent = 0;
      int          stall_grants = 0;
      for (int i = 0; i < 4; i++) addrs[i] = BASE + 32'(4 * $urandom_range(0, 16383));
      for (int c = 0; c < 40; c++) begin
         tick();
         if (sent == 4 && exp_q.size() == 0) break;
         mem_gnt_i    = (c >= 5);
         instr_req_i  = (sent < 4);
         instr_addr_i = (sent < 4) ? addrs[sent] : 32'h0;
         @(negedge clk_i);
         if (c < 5 && instr_gnt_o === 1'b1) stall_grants++;
         if (c == 4) begin
            checks++;
            if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL bp_full_gnt: got %b expected 0", instr_gnt_o); end
         end
         if (instr_gnt_o === 1'b1) sent++;
      end
      instr_req_i = 1'b0;
      mem_gnt_i   = 1'b1;
      checks++;
      if (stall_grants != MAX_OUT) begin errors++; $display("FAIL bp_grants: got %0d expected %0d", stall_grants, MAX_OUT); end
      checks++;
      if (sent != 4 || exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got sent=%0d pending=%0d expected 4 0", sent, exp_q.size()); end
   endtask

   task automatic test_random();
      localparam int N = 120;
      logic [31:0] addrs [N];
      int          idx  = 0;
      logic        hold = 1'b0;
      addrs[0] = BASE - 32'd4;
      addrs[1] = BASE;
      addrs[2] = BASE + REGION - 32'd4;
      addrs[3] = BASE + REGION;
      addrs[4] = 32'hFFFF_FFFC;
      addrs[5] = 32'h0;
      for (int i = 6; i < N; i++) begin
         if ($urandom_range(0, 9) < 7) addrs[i] = BASE + 32'(4 * $urandom_range(0, 16383)) + 32'($urandom_range(0, 3));
         else                          addrs[i] = $urandom();
      end
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (idx == N && exp_q.size() == 0) break;
         mem_gnt_i = ($urandom_range(0, 9) < 7);
         if (!hold && idx < N) hold = ($urandom_range(0, 3) != 0);
         instr_req_i  = hold;
         instr_addr_i = hold ? addrs[idx] : $urandom();
         @(negedge clk_i);
         if (instr_gnt_o === 1'b1) begin
            idx++;
            hold = 1'b0;
         end
      end
      instr_req_i = 1'b0;
      mem_gnt_i   = 1'b1;
      checks++;
      if (idx != N || exp_q.size() != 0) begin errors++; $display("FAIL random_drain: got sent=%0d pending=%0d expected %0d 0", idx, exp_q.size(), N); end
   endtask

   task automatic test_reset_mid();
      resp_t e;
      int    t = -1;
      tick();
      mem_gnt_i    = 1'b0;
      instr_req_i  = 1'b1;
      instr_addr_i = BASE + 32'd8;
      tick();
      instr_addr_i = BASE + 32'd12;
      tick();
      rst_ni = 1'b0;
      #1;
      checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL midrst_gnt: got %b expected 0", instr_gnt_o); end
      checks++; if (instr_rvalid_o !== 1'b0 || instr_err_o !== 1'b0 || instr_rdata_o !== 32'h0) begin
         errors++; $display("FAIL midrst_resp: got rvalid=%b err=%b rdata=%h expected all 0", instr_rvalid_o, instr_err_o, instr_rdata_o);
      end
      checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== '0) begin errors++; $display("FAIL midrst_mem: got req=%b addr=%h expected 0 0", mem_req_o, mem_addr_o); end
      repeat (2) @(posedge clk_i);
      #1;
      instr_req_i = 1'b0;
      mem_gnt_i   = 1'b1;
      rst_ni      = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         checks++;
         if (instr_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL midrst_stale[%0d]: got rvalid=%b mem_req=%b expected 0 0", c, instr_rvalid_o, mem_req_o);
         end
         tick();
      end
      instr_req_i  = 1'b1;
      instr_addr_i = BASE + 32'd16;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         if (instr_gnt_o === 1'b1) begin t = c; break; end
         tick();
      end
      checks++;
      if (t < 0) begin errors++; $display("FAIL midrst_gnt_timeout: got no grant expected grant"); end
      tick();
      instr_req_i = 1'b0;
      @(negedge clk_i);
      checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL midrst_early: got rvalid=%b expected 0", instr_rvalid_o); end
      tick();
      @(negedge clk_i);
      e = model(BASE + 32'd16);
      checks++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== e.data || instr_err_o !== 1'b0) begin
         errors++; $display("FAIL midrst_resp_after: got rvalid=%b rdata=%h err=%b expected 1 %h 0", instr_rvalid_o, instr_rdata_o, instr_err_o, e.data);
      end
      repeat (2) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16384; i++) sram[i] = $urandom();
      instr_req_i  = 1'b0;
      instr_addr_i = '0;
      mem_gnt_i    = 1'b1;
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_out_of_range();
      test_interleaved();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
